led_pwm_sequencer: RTL and testbench

//  Downstream LED stage fed by the PLL-derived clock: drives the eight board LED output buffers with
//  8-bit PWM patterns (breathe, chase, static) instead of raw counter bits. Sits between the
//  clk_pll domain logic and the GENERIC_IOB LED outputs; one instance per board.

---
 rtl/led_pwm_pkg.sv | 21 ++
 rtl/led_pwm_channel.sv | 32 +++
 rtl/led_pwm_sequencer.sv | 132 +++++++++++++
 tb/tb_led_pwm_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared encodings and helpers for the LED PWM sequencer.
// Duty values are 8-bit; mode 3 is reserved and decodes as static.
package led_pwm_pkg;

  typedef logic [7:0] duty_t;

  localparam logic [1:0] MODE_BREATHE = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_STATIC  = 2'd2;

  localparam duty_t DUTY_FULL       = 8'hFF;
  localparam duty_t CHASE_TAIL_DUTY = 8'd64;

  // Perceptual map (d*d)>>8; full scale stays full so "always on" is preserved.
  function automatic duty_t gamma_map(input duty_t d);
    logic [15:0] sq;
    sq = {8'd0, d} * {8'd0, d};
    return (d == DUTY_FULL) ? DUTY_FULL : sq[15:8];
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: optional gamma map (LED_GAMMA_EN) and registered PWM compare.
// Without LED_GAMMA_EN the duty is compared linearly.
module led_pwm_channel
  import led_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [7:0] pwm_cnt,
  input  logic [7:0] duty,
  output logic       led
);

  duty_t duty_eff;
  logic  led_q, led_d;

`ifdef LED_GAMMA_EN
  assign duty_eff = gamma_map(duty);
`else
  assign duty_eff = duty;
`endif

  assign led_d = enable & ((duty_eff == DUTY_FULL) | (pwm_cnt < duty_eff));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) led_q <= 1'b0;
    else         led_q <= led_d;
  end

  assign led = led_q;

endmodule

// File: rtl/led_pwm_sequencer.sv
// Eight-LED PWM sequencer (breathe / chase / static); duties change only at frame wrap.
// Optional gamma-corrected compare is enabled by defining LED_GAMMA_EN.
module led_pwm_sequencer
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE     = 16,
  parameter int BREATHE_STEP = 4,
  parameter int CHASE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] static_pattern,
  output logic [7:0] leds,
  output logic       frame_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (CHASE_FRAMES > 1) ? $clog2(CHASE_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CHF_LAST = CW'(CHASE_FRAMES - 1);
  localparam logic [8:0]    STEP9    = 9'(BREATHE_STEP);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_q, pwm_d;
  logic          frame_tick_q, frame_tick_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    pattern_q, pattern_d;
  logic [7:0]    level_q, level_d;
  logic          dir_up_q, dir_up_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] frm_q, frm_d;
  duty_t         duty_q [8];
  duty_t         duty_d [8];
  logic          step, frame_end;
  logic [8:0]    sum9;

  assign step      = enable && (presc_q == PRE_LAST);
  assign frame_end = step && (pwm_q == 8'hFF);
  assign sum9      = {1'b0, level_q} + STEP9;

  always_comb begin
    presc_d      = (!enable || step) ? '0 : presc_q + 1'b1;
    pwm_d        = !enable ? 8'd0 : (step ? pwm_q + 8'd1 : pwm_q);
    frame_tick_d = frame_end;
    // Inputs sampled at frame end drive the duties of the frame that starts now.
    mode_d       = frame_end ? mode : mode_q;
    pattern_d    = frame_end ? static_pattern : pattern_q;
    level_d      = level_q;
    dir_up_d     = dir_up_q;
    idx_d        = idx_q;
    frm_d        = frm_q;
    duty_d       = duty_q;
    if (frame_end) begin
      case (mode_d)
        MODE_BREATHE: begin
          if (dir_up_q) begin
            if (sum9 >= 9'd255) begin
              level_d  = 8'hFF;
              dir_up_d = 1'b0;
            end else begin
              level_d = sum9[7:0];
            end
          end else if ({1'b0, level_q} <= STEP9) begin
            level_d  = 8'd0;
            dir_up_d = 1'b1;
          end else begin
            level_d = level_q - STEP9[7:0];
          end
          for (int i = 0; i < 8; i++) duty_d[i] = level_d;
        end
        MODE_CHASE: begin
          if (frm_q == CHF_LAST) begin
            frm_d = '0;
            idx_d = idx_q + 3'd1;
          end else begin
            frm_d = frm_q + 1'b1;
          end
          for (int i = 0; i < 8; i++) begin
            if (3'(i) == idx_d)               duty_d[i] = DUTY_FULL;
            else if (3'(i) == idx_d - 3'd1)   duty_d[i] = CHASE_TAIL_DUTY;
            else                              duty_d[i] = 8'd0;
          end
        end
        default: begin
          for (int i = 0; i < 8; i++) duty_d[i] = pattern_d[i] ? DUTY_FULL : 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q      <= '0;
      pwm_q        <= 8'd0;
      frame_tick_q <= 1'b0;
      mode_q       <= MODE_BREATHE;
      pattern_q    <= 8'd0;
      level_q      <= 8'd0;
      dir_up_q     <= 1'b1;
      idx_q        <= 3'd0;
      frm_q        <= '0;
      for (int i = 0; i < 8; i++) duty_q[i] <= 8'd0;
    end else begin
      presc_q      <= presc_d;
      pwm_q        <= pwm_d;
      frame_tick_q <= frame_tick_d;
      mode_q       <= mode_d;
      pattern_q    <= pattern_d;
      level_q      <= level_d;
      dir_up_q     <= dir_up_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      duty_q       <= duty_d;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_ch
    led_pwm_channel u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .enable  (enable),
      .pwm_cnt (pwm_q),
      .duty    (duty_q[g]),
      .led     (leds[g])
    );
  end

  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Directed bench for led_pwm_sequencer (PRESCALE=1, BREATHE_STEP=64, CHASE_FRAMES=2).
// Expected LED on-counts follow the gamma map when LED_GAMMA_EN is defined.
module tb_led_pwm_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] static_pattern = 8'd0;
  logic [7:0] leds;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;
  int hc [8];
  int tick_pos;

`ifdef LED_GAMMA_EN
  localparam int EXP_B [9] = '{16, 64, 144, 256, 142, 63, 15, 0, 16};
  localparam int TAIL_ON   = 16;
  localparam int EN_F0     = 64;
  localparam int EN_F1     = 144;
`else
  localparam int EXP_B [9] = '{64, 128, 192, 256, 191, 127, 63, 0, 64};
  localparam int TAIL_ON   = 64;
  localparam int EN_F0     = 128;
  localparam int EN_F1     = 192;
`endif

  led_pwm_sequencer #(.PRESCALE(1), .BREATHE_STEP(64), .CHASE_FRAMES(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .mode           (mode),
    .static_pattern (static_pattern),
    .leds           (leds),
    .frame_tick     (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic apply_reset(input logic [1:0] m, input logic [7:0] p);
    @(negedge clk);
    resetn = 1'b0;
    enable = 1'b1;
    mode = m;
    static_pattern = p;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_tick(output bit got);
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (frame_tick) got = 1'b1;
    end
  endtask

  // Collects per-LED on-counts over the 256 samples following a frame_tick.
  task automatic measure_frame();
    for (int i = 0; i < 8; i++) hc[i] = 0;
    tick_pos = -1;
    for (int j = 1; j <= 256; j++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) if (leds[i]) hc[i]++;
      if (frame_tick && tick_pos < 0) tick_pos = j;
    end
  endtask

  task automatic test_reset();
    bit got;
    int pos, highs;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    total++;
    if (leds !== 8'h00 || frame_tick !== 1'b0) begin
      bad++; $display("FAIL reset_state: leds=%h tick=%b want 00/0", leds, frame_tick);
    end
    apply_reset(2'd2, 8'hFF);
    wait_tick(got);
    total++;
    if (!got) begin bad++; $display("FAIL reset_first_tick: no frame_tick seen"); end
    repeat (10) @(negedge clk);
    total++;
    if (leds !== 8'hFF) begin bad++; $display("FAIL reset_prerun_leds: leds=%h want ff", leds); end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (leds !== 8'h00) begin bad++; $display("FAIL reset_async_leds: leds=%h want 00", leds); end
    total++;
    if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_async_tick: tick=%b want 0", frame_tick); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    pos = -1;
    highs = 0;
    for (int j = 1; j <= 300 && pos < 0; j++) begin
      @(negedge clk);
      if (leds != 8'h00) highs++;
      if (frame_tick) pos = j;
    end
    total++;
    if (pos != 256) begin bad++; $display("FAIL reset_tick_latency: tick at %0d want 256", pos); end
    total++;
    if (highs != 0) begin bad++; $display("FAIL reset_frame0_dark: lit samples=%0d want 0", highs); end
  endtask

  task automatic test_breathe();
    bit got;
    apply_reset(2'd0, 8'h00);
    wait_tick(got);
    total++;
    if (!got) begin bad++; $display("FAIL breathe_tick: no frame_tick seen"); end
    for (int k = 0; k < 9; k++) begin
      measure_frame();
      for (int i = 0; i < 8; i++) begin
        total++;
        if (hc[i] != EXP_B[k]) begin
          bad++; $display("FAIL breathe_frame%0d led%0d: on=%0d want %0d", k + 1, i, hc[i], EXP_B[k]);
        end
      end
      total++;
      if (tick_pos != 256) begin
        bad++; $display("FAIL breathe_tick_frame%0d: tick at %0d want 256", k + 1, tick_pos);
      end
    end
  endtask

  task automatic test_chase();
    bit got;
    int idx, want;
    apply_reset(2'd1, 8'h00);
    wait_tick(got);
    total++;
    if (!got) begin bad++; $display("FAIL chase_tick: no frame_tick seen"); end
    for (int n = 1; n <= 17; n++) begin
      measure_frame();
      idx = (n / 2) % 8;
      for (int i = 0; i < 8; i++) begin
        if (i == idx)                want = 256;
        else if (i == (idx + 7) % 8) want = TAIL_ON;
        else                         want = 0;
        total++;
        if (hc[i] != want) begin
          bad++; $display("FAIL chase_frame%0d led%0d: on=%0d want %0d", n, i, hc[i], want);
        end
      end
    end
  endtask

  task automatic check_static_frame(input string name, input logic [7:0] pat);
    measure_frame();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (hc[i] != (pat[i] ? 256 : 0)) begin
        bad++; $display("FAIL %s led%0d: on=%0d want %0d", name, i, hc[i], pat[i] ? 256 : 0);
      end
    end
    total++;
    if (tick_pos != 256) begin bad++; $display("FAIL %s_tick: tick at %0d want 256", name, tick_pos); end
  endtask

  task automatic test_static();
    bit got, got2, ok;
    apply_reset(2'd2, 8'h3C);
    wait_tick(got);
    total++;
    if (!got) begin bad++; $display("FAIL static_tick: no frame_tick seen"); end
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (leds !== 8'h3C) ok = 1'b0;
    end
    static_pattern = 8'hA5;
    got2 = 1'b0;
    for (int j = 0; j < 300 && !got2; j++) begin
      @(negedge clk);
      if (leds !== 8'h3C) ok = 1'b0;
      if (frame_tick) got2 = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL static_midframe_hold: leds=%h want 3c", leds); end
    total++;
    if (!got2) begin bad++; $display("FAIL static_tick2: no frame_tick seen"); end
    check_static_frame("static_a5", 8'hA5);
    mode = 2'd3;
    static_pattern = 8'h5A;
    check_static_frame("static_a5_hold", 8'hA5);
    check_static_frame("reserved_5a", 8'h5A);
  endtask

  task automatic test_enable_drop();
    bit got, dark, quiet;
    apply_reset(2'd0, 8'h00);
    wait_tick(got);
    total++;
    if (!got) begin bad++; $display("FAIL en_tick: no frame_tick seen"); end
    measure_frame();
    repeat (50) @(negedge clk);
    enable = 1'b0;
    dark = 1'b1;
    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (leds !== 8'h00) dark = 1'b0;
      if (frame_tick !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!dark) begin bad++; $display("FAIL en_off_leds: leds=%h want 00", leds); end
    total++;
    if (!quiet) begin bad++; $display("FAIL en_off_tick: frame_tick=1 want 0"); end
    enable = 1'b1;
    measure_frame();
    total++;
    if (hc[3] != EN_F0) begin bad++; $display("FAIL en_restart_duty: on=%0d want %0d", hc[3], EN_F0); end
    total++;
    if (tick_pos != 256) begin bad++; $display("FAIL en_restart_tick: tick at %0d want 256", tick_pos); end
    measure_frame();
    total++;
    if (hc[5] != EN_F1) begin bad++; $display("FAIL en_level_held: on=%0d want %0d", hc[5], EN_F1); end
  endtask

  initial begin
    test_reset();
    test_breathe();
    test_chase();
    test_static();
    test_enable_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
